fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the async FIFO write port (winc/wdata/wfull) among NREQ requesters in the write clock domain.
- Each requester uses a valid/ready stream with a last flag. A grant is held for one burst of at most BURST words, then re-arbitrated.
- The block sits directly in front of the FIFO write side. It never writes while wfull is high, so no word is dropped.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width; must match the FIFO data width.
- BURST, 4, maximum words per grant (1..64).

Ports:
- clk  input  1  write-domain clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  input  NREQ  marks the final word of a requester's burst.
- req_ready  output  NREQ  per-requester accept, combinational.
- wfull  input  1  FIFO full flag, already in the clk domain.
- winc  output  1  FIFO write strobe, combinational.
- wdata  output  WIDTH  FIFO write data, combinational mux.
- grant_id  output  clog2(NREQ)  current owner, registered.
- busy  output  1  high while in XFER, registered.

Behaviour:
- Reset:
  - clk is the single clock; rst is asynchronous and active-high.
  - On reset: state=IDLE, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0.
  - Combinational outputs during reset: winc=0, req_ready=0, wdata=0.
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_valid is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register it into grant_id, clear beat_cnt, go to XFER.
  - If no req_valid is high, stay in IDLE.
  - Arbitration costs exactly one cycle. The first word is accepted no earlier than the cycle after the request is seen.
- XFER, with g = grant_id:
  - req_ready[g] = ~wfull. All other req_ready bits are 0.
  - winc = req_valid[g] & ~wfull.
  - wdata = req_data[g] when winc=1, otherwise 0.
  - A beat occurs when winc=1; beat_cnt increments on each beat.
- XFER exit, to IDLE on the next edge:
  - Case (a): a beat with req_last[g]=1.
  - Case (b): a beat with beat_cnt==BURST-1.
  - Case (c): req_valid[g]=0 in any XFER cycle. This releases an idle owner after one cycle.
  - On every exit: rr_ptr <= (g+1) mod NREQ, busy <= 0.
- wfull stall:
  - While wfull=1 in XFER: no beat, grant held, beat_cnt frozen, no exit. This holds even with req_valid[g]=1.
  - Case (c) still applies when valid is low.
- Simultaneous events:
  - last together with burst limit gives a single exit.
  - A requester not granted keeps valid asserted. It is served in rotation within NREQ grants, so there is no starvation.
- The owner may change its word only after a beat (stream rule). The arbiter does not register data.
- Reset mid-XFER:
  - Immediate return to IDLE; winc drops asynchronously.
  - A beat in progress at the reset edge is not counted.
- Width rules:
  - beat_cnt is clog2(BURST+1) bits.
  - rr_ptr and grant_id are clog2(NREQ) bits.
  - For non-power-of-2 NREQ, the pointer wraps from NREQ-1 to 0.

Test Plan:
- Single requester: req 1 streams 3 words 0x11, 0x22, 0x33 with last on 0x33, wfull=0. Expected: one IDLE cycle, then winc high 3 consecutive cycles, wdata=0x11, 0x22, 0x33, grant_id=1, then IDLE with rr_ptr=2.
- Burst limit: req 0 streams 10 words with no last, BURST=4. Expected: 4 beats, then 1 IDLE cycle, repeated as 4, 4, 2 beats; rr_ptr=1 after each exit.
- Fairness: all 4 requesters continuously valid, BURST=4. Expected: grant order 0, 1, 2, 3, 0, ...; each grant gives exactly 4 beats; no requester skipped.
- wfull stall: wfull=1 for cycles 2..5 of a req 2 burst. Expected: winc=0 and req_ready[2]=0 in those cycles; beat_cnt frozen; transfer resumes in cycle 6; total word count and order preserved.
- Valid drop: owner req 3 deasserts valid after 1 word. Expected: exit after that cycle; rr_ptr=0; pending req 0 granted next.
- Reset in XFER: assert rst mid-burst. Expected: winc=0 and busy=0 immediately; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one async-FIFO write port among NREQ valid/ready
// streams. Each grant carries at most BURST words and ends early on last or an idle owner.
//
// Handshake: a word from requester i moves when req_valid[i] & req_ready[i] are both
// high on a rising edge. Once valid is raised, the word must stay stable until that
// beat. req_ready is only ever offered to the current owner, and only when the FIFO
// is not full, so winc is exactly the owner's beat.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [WIDTH-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            busy_q, busy_d;

  logic            in_xfer;
  logic            owner_valid;
  logic            owner_last;
  logic [WIDTH-1:0] owner_data;
  logic            beat;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   next_ptr;
  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0] valid_rot;
  int              pick_sum;

  assign in_xfer = (state_q == S_XFER) && !rst;

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == PW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Rotate valids so bit k is requester (rr_ptr + k) mod NREQ; the lowest set bit wins.
  always_comb begin
    valid_dbl  = {req_valid, req_valid} >> rr_ptr_q;
    valid_rot  = valid_dbl[NREQ-1:0];
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    pick_sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && valid_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = int'(rr_ptr_q) + k;
        if (pick_sum >= NREQ) begin
          pick_sum = pick_sum - NREQ;
        end
        pick_idx = PW'(pick_sum);
      end
    end
  end

  assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + PW'(1);

  always_comb begin
    winc = in_xfer && owner_valid && !wfull;
    beat = winc;
    wdata = winc ? owner_data : '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = in_xfer && !wfull && (grant_q == PW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_XFER;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      S_XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
        // An idle owner is released at once; a stalled but valid owner keeps the grant.
        if (!owner_valid || (beat && (owner_last || beat_cnt_q == BEAT_MAX))) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester word queues drive the streams, a grant-level
// model predicts the outputs each cycle, and directed scenarios pin literal results.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int PW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [WIDTH-1:0]      wdata;
  logic [PW-1:0]         grant_id;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant_id(grant_id), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;

  logic [WIDTH:0]   src_q [NREQ][$];   // {last, data} words waiting per requester
  logic [WIDTH-1:0] exp_q [$];
  bit               pres [NREQ];       // requester currently holding valid high
  int               valid_pct = 100;
  int               n_enq = 0;
  int               n_written = 0;

  // grant-level model
  int m_owner = -1;
  int m_ptr   = 0;
  int m_gid   = 0;
  int m_cnt   = 0;

  logic             obs_winc;
  logic [WIDTH-1:0] obs_wdata;
  int               obs_gid;
  logic             obs_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_word(input int r, input logic [WIDTH-1:0] d, input logic last);
    src_q[r].push_back({last, d});
    n_enq++;
  endtask

  // driver
  task automatic drive();
    logic [WIDTH:0] w;
    for (int i = 0; i < NREQ; i++) begin
      if (!pres[i] && src_q[i].size() > 0 && $urandom_range(0, 99) < valid_pct) pres[i] = 1'b1;
      req_valid[i] = pres[i];
      if (pres[i]) begin
        w = src_q[i][0];
        req_data[i*WIDTH +: WIDTH] = w[WIDTH-1:0];
        req_last[i] = w[WIDTH];
      end else begin
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model, retire beats.
  task automatic step(input logic wf);
    logic [WIDTH:0]  w;
    logic            exp_winc;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    drive();
    wfull = wf;
    #1;
    exp_winc  = 1'b0;
    exp_ready = '0;
    w         = '0;
    if (m_owner >= 0) begin
      exp_ready[m_owner] = !wf;
      if (pres[m_owner] && !wf) begin
        exp_winc = 1'b1;
        w = src_q[m_owner][0];
        exp_q.push_back(w[WIDTH-1:0]);
      end
    end
    chk("winc", 32'(winc), 32'(exp_winc));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    if (winc) begin
      n_written++;
      if (exp_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
      else chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
    end else begin
      chk("wdata_idle", 32'(wdata), 32'd0);
    end
    exp_q.delete();
    obs_winc  = winc;
    obs_wdata = wdata;
    obs_gid   = int'(grant_id);
    obs_busy  = busy;

    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c = (m_ptr + k) % NREQ;
        if (pres[c]) begin
          m_owner = c;
          m_gid   = c;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!pres[m_owner]) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else if (!wf) begin
      m_cnt++;
      if (w[WIDTH] || m_cnt == BURST) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (pres[i] && req_ready[i]) begin
        void'(src_q[i].pop_front());
        pres[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int left;
    bit pending;
    left = budget;
    pending = 1'b1;
    while (pending && left > 0) begin
      step(1'b0);
      left--;
      pending = (m_owner >= 0);
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) pending = 1'b1;
    end
    if (pending) chk("drain_timeout", 32'd1, 32'd0);
    step(1'b0);
  endtask

  initial begin
    int pat;
    int bseq [$];
    logic [WIDTH-1:0] single_exp [3];
    single_exp[0] = 8'h11;
    single_exp[1] = 8'h22;
    single_exp[2] = 8'h33;

    // reset state, with every requester asking, must leave all strobes low
    rst = 1'b1;
    wfull = 1'b0;
    req_valid = '1;
    req_last = '0;
    req_data = NREQ*WIDTH'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // single requester, three words
    push_word(1, 8'h11, 1'b0);
    push_word(1, 8'h22, 1'b0);
    push_word(1, 8'h33, 1'b1);
    step(1'b0);
    chk("single_arb_winc", 32'(obs_winc), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      chk("single_winc", 32'(obs_winc), 32'd1);
      chk("single_wdata", 32'(obs_wdata), 32'(single_exp[k]));
      chk("single_gid", 32'(obs_gid), 32'd1);
    end
    step(1'b0);
    chk("single_done_busy", 32'(obs_busy), 32'd0);
    // pointer now 2: requester 3 must beat requester 0
    push_word(0, 8'h44, 1'b1);
    push_word(3, 8'h77, 1'b1);
    step(1'b0);
    step(1'b0);
    chk("ptr2_gid", 32'(obs_gid), 32'd3);
    chk("ptr2_wdata", 32'(obs_wdata), 32'h77);
    drain(50);

    // burst limit: ten words, no last
    for (int k = 0; k < 10; k++) push_word(0, WIDTH'(8'h80 + k), 1'b0);
    pat = 0;
    for (int s = 0; s < 16; s++) begin
      step(1'b0);
      pat = pat | (int'(obs_winc) << s);
    end
    chk("burst_pattern", 32'(pat), 32'h1BDE);
    drain(50);

    // fairness: bring the pointer to 0, then all four stream eight words
    push_word(3, 8'h5A, 1'b1);
    drain(50);
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++) push_word(r, WIDTH'(r * 16 + k), 1'b0);
    for (int s = 0; s < 80; s++) begin
      step(1'b0);
      if (obs_winc) bseq.push_back(obs_gid);
    end
    chk("fair_beats", 32'(bseq.size()), 32'd32);
    for (int k = 0; k < bseq.size() && k < 32; k++)
      chk("fair_order", 32'(bseq[k]), 32'((k / BURST) % NREQ));
    drain(50);

    // wfull stall in XFER cycles 2..5 of a requester 2 burst
    for (int k = 0; k < 6; k++) push_word(2, WIDTH'(8'hA0 + k), k == 5);
    pat = 0;
    for (int s = 0; s < 12; s++) begin
      step(s >= 2 && s <= 5);
      pat = pat | (int'(obs_winc) << s);
    end
    chk("stall_pattern", 32'(pat), 32'hDC2);
    drain(50);

    // valid drop: owner 3 goes idle after one word
    push_word(3, 8'h33, 1'b0);
    step(1'b0);
    push_word(0, 8'h55, 1'b1);
    push_word(1, 8'h66, 1'b1);
    step(1'b0);
    chk("drop_beat", 32'(obs_wdata), 32'h33);
    step(1'b0);
    chk("drop_exit_winc", 32'(obs_winc), 32'd0);
    chk("drop_exit_busy", 32'(obs_busy), 32'd1);
    step(1'b0);
    step(1'b0);
    chk("drop_next_gid", 32'(obs_gid), 32'd0);
    chk("drop_next_wdata", 32'(obs_wdata), 32'h55);
    drain(50);

    // reset in the middle of a requester 2 burst
    for (int k = 0; k < 4; k++) push_word(2, WIDTH'(8'hC0 + k), k == 3);
    push_word(3, 8'hD0, 1'b1);
    repeat (3) step(1'b0);
    drive();
    #1;
    chk("pre_rst_winc", 32'(winc), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_winc", 32'(winc), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("post_rst_gid", 32'(obs_gid), 32'd2);
    chk("post_rst_wdata", 32'(obs_wdata), 32'hC2);
    drain(50);

    // randomized traffic with FIFO back-pressure
    valid_pct = 70;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 15) begin
        int r = $urandom_range(0, NREQ - 1);
        int n = $urandom_range(1, 6);
        bit tail = $urandom_range(0, 1) == 1;
        if (src_q[r].size() < 12)
          for (int k = 0; k < n; k++) push_word(r, WIDTH'($urandom), tail && (k == n - 1));
      end
      step($urandom_range(0, 99) < 20);
    end
    valid_pct = 100;
    drain(600);

    chk("words_total", 32'(n_written), 32'(n_enq));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
